// File: rtl/nf10_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nf10_axis_rr_arbiter
//
// Packet-granular round-robin arbiter. It shares one 64-bit AXI4-Stream input
// of the downstream 64->256 converter among four 64-bit requesters. A port is
// granted for one whole packet, and priority rotates after every packet.
// Data, strobes, tuser and tlast pass through combinationally and unchanged.
// There is no buffering.
//
// Optional feature macro: NF10_AXIS_RR_ARBITER_STATS_EN
//   When defined, adds the pkt_cnt output: four 32-bit wrapping counters of
//   completed packets, one per port. They are cleared only by axi_reset.
//
// Ports:
//   axi_aclk, axi_reset   clock; asynchronous active-high reset
//   s_axis_*              four packed slave streams; port i uses slice i
//   s_axis_tready         per-port ready; only the granted port sees m_axis_tready
//   m_axis_*              master stream to the converter
//   m_axis_tready         ready from the converter
//   pkt_cnt               (stats build only) per-port packet counters, 4 x 32
// -----------------------------------------------------------------------------
module nf10_axis_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS        = 4
) (
    input  logic                                        axi_aclk,
    input  logic                                        axi_reset,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                        m_axis_tvalid,
    output logic                                        m_axis_tlast,
    input  logic                                        m_axis_tready
`ifdef NF10_AXIS_RR_ARBITER_STATS_EN
    ,
    output logic [C_NUM_PORTS*32-1:0]                   pkt_cnt
`endif
);

    localparam int SW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  grant_r;
    logic [1:0]  grant_s;
    logic [1:0]  ptr_r;
    logic [1:0]  ptr_s;
    logic        last_hs_s;

    // First requesting port when scanning base, base+1, base+2, base+3 (mod 4).
    // Only called with at least one request set. If no request is set, it
    // returns base.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = base + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // End of the granted packet: the tlast beat is accepted by the converter.
    assign last_hs_s = (state_r == ST_SEND) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // State, grant and priority-pointer registers.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_r <= ST_IDLE;
            grant_r <= 2'd0;
            ptr_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

    // Next-state logic. The grant is sampled once in IDLE and then held until
    // the tlast handshake. Gaps in tvalid never release it.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    state_s = ST_SEND;
                    grant_s = rr_pick(s_axis_tvalid, ptr_r);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    state_s = ST_IDLE;
                    ptr_s   = grant_r + 2'd1;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Zero-latency pass-through mux of the granted port. Everything is zero in IDLE.
    always_comb begin
        m_axis_tdata  = {C_AXIS_DATA_WIDTH{1'b0}};
        m_axis_tstrb  = {SW{1'b0}};
        m_axis_tuser  = {C_AXIS_TUSER_WIDTH{1'b0}};
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = {C_NUM_PORTS{1'b0}};
        if (state_r == ST_SEND) begin
            m_axis_tdata           = s_axis_tdata[grant_r*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            m_axis_tstrb           = s_axis_tstrb[grant_r*SW +: SW];
            m_axis_tuser           = s_axis_tuser[grant_r*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
            m_axis_tvalid          = s_axis_tvalid[grant_r];
            m_axis_tlast           = s_axis_tlast[grant_r];
            s_axis_tready[grant_r] = m_axis_tready;
        end else begin
            s_axis_tready = {C_NUM_PORTS{1'b0}};
        end
    end

`ifdef NF10_AXIS_RR_ARBITER_STATS_EN
    logic [C_NUM_PORTS*32-1:0] pkt_cnt_r;

    // Per-port packet counters. They wrap naturally at 32 bits.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            pkt_cnt_r <= {(C_NUM_PORTS*32){1'b0}};
        end else if (last_hs_s) begin
            pkt_cnt_r[grant_r*32 +: 32] <= pkt_cnt_r[grant_r*32 +: 32] + 32'd1;
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign pkt_cnt = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_nf10_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for nf10_axis_rr_arbiter.
// - A directed table of per-cycle vectors.
// - Hand-written sequences: contention order, backpressure, reset mid-packet,
//   and stats.
// - Randomized traffic compared every cycle against a packet-level reference
//   model. The model has a busy flag, an owner and a priority pointer, and
//   applies the round-robin rule.
// -----------------------------------------------------------------------------
module tb_nf10_axis_rr_arbiter;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic [255:0]  s_tdata;
    logic [31:0]   s_tstrb;
    logic [511:0]  s_tuser;
    logic [3:0]    s_tvalid;
    logic [3:0]    s_tlast;
    logic [3:0]    s_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tstrb;
    logic [127:0]  m_tuser;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_ready;
`ifdef NF10_AXIS_RR_ARBITER_STATS_EN
    logic [127:0]  pkt_cnt;
`endif

    nf10_axis_rr_arbiter dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_ready)
`ifdef NF10_AXIS_RR_ARBITER_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    logic [31:0] mcnt [4];

    // sources
    bit  en [4];
    int  pkt [4];
    int  bidx [4];
    int  plen [4];
    int  limit [4];
    int  fixed_len;
    int  vmode;        // 0: always valid while active, 1: random gaps

    // observation
    logic [63:0] obs_mdata;
    logic        obs_mvalid;
    logic        obs_mlast;
    logic [3:0]  obs_sready;
    logic [3:0]  hs;
    bit          prev_hold;
    logic [63:0] prev_data;
    int          cyc;
    int          done_port[$];
    int          done_cyc[$];

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       ev;
        logic       el;
        logic [3:0] er;
        int         ep;
    } vec_t;
    vec_t tbl [16];

    function automatic logic [63:0] mk_data(input int p, input int k, input int b);
        return {8'(p), 24'(k), 32'(b)};
    endfunction

    function automatic logic [127:0] mk_user(input int p, input int k, input int b);
        return {~mk_data(p, k, b), mk_data(p, k, b)};
    endfunction

    function automatic logic [7:0] mk_strb(input int p, input int b);
        return 8'(8'h11 * (p + 1)) ^ 8'(b);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_env();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 32'd0; en[i] = 1'b0; pkt[i] = 0; bidx[i] = 0;
            plen[i] = 2; limit[i] = 1000000;
        end
        fixed_len = 2; vmode = 0; prev_hold = 1'b0;
        done_port.delete(); done_cyc.delete();
    endtask

    task automatic do_reset();
        axi_reset = 1'b1;
        s_tvalid = 4'b0; s_tlast = 4'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
        m_ready = 1'b0;
        reset_env();
        repeat (2) @(posedge clk);
        #1 axi_reset = 1'b0;
    endtask

    function automatic int new_len();
        return (fixed_len > 0) ? fixed_len : int'($urandom_range(4, 1));
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = en[i] && (pkt[i] < limit[i]) && (vmode == 0 || $urandom_range(3, 0) != 0);
            s_tlast[i]  = (bidx[i] == plen[i] - 1);
            s_tdata[i*64 +: 64]   = mk_data(i, pkt[i], bidx[i]);
            s_tuser[i*128 +: 128] = mk_user(i, pkt[i], bidx[i]);
            s_tstrb[i*8 +: 8]     = mk_strb(i, bidx[i]);
        end
    endtask

    task automatic advance_sources();
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (bidx[i] == plen[i] - 1) begin
                    bidx[i] = 0; pkt[i]++; plen[i] = new_len();
                end else begin
                    bidx[i]++;
                end
            end
        end
    endtask

    // Compare DUT outputs against the model, then move the model one edge on.
    task automatic model_cycle();
        logic [63:0]  e_data;
        logic [7:0]   e_strb;
        logic [127:0] e_user;
        logic         e_valid;
        logic         e_last;
        logic [3:0]   e_ready;
        bit           found;
        e_data = '0; e_strb = '0; e_user = '0; e_valid = 1'b0; e_last = 1'b0; e_ready = 4'b0;
        if (m_busy) begin
            e_data  = s_tdata[m_owner*64 +: 64];
            e_strb  = s_tstrb[m_owner*8 +: 8];
            e_user  = s_tuser[m_owner*128 +: 128];
            e_valid = s_tvalid[m_owner];
            e_last  = s_tlast[m_owner];
            e_ready = 4'(m_ready) << m_owner;
        end
        chk("model_mvalid", m_tvalid, e_valid);
        chk("model_mlast", m_tlast, e_last);
        chk("model_mdata", m_tdata, e_data);
        chk("model_mstrb", m_tstrb, e_strb);
        chk("model_muser", m_tuser, e_user);
        chk("model_sready", s_tready, e_ready);
        if (m_busy) begin
            if (s_tvalid[m_owner] && m_ready && s_tlast[m_owner]) begin
                m_busy = 1'b0;
                m_ptr = (m_owner + 1) % 4;
                mcnt[m_owner] = mcnt[m_owner] + 32'd1;
            end
        end else if (|s_tvalid) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && s_tvalid[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_busy = 1'b1;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        obs_mdata = m_tdata; obs_mvalid = m_tvalid; obs_mlast = m_tlast; obs_sready = s_tready;
        hs = s_tvalid & s_tready;
        if (prev_hold) chk("hold_stable", m_tdata, prev_data);
        prev_hold = m_tvalid && !m_ready;
        prev_data = m_tdata;
        if (m_tvalid && m_ready && m_tlast) begin
            done_port.push_back(int'(m_tdata[63:56]));
            done_cyc.push_back(cyc);
        end
        model_cycle();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic src_tick();
        drive_sources();
        tick();
        advance_sources();
    endtask

    initial begin
        int  hs1;
        bit  ok;
        cyc = 0;
        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0100,  2};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100,  2};
        tbl[4]  = '{4'b1001, 4'b1001, 1'b1, 1'b0, 1'b0, 4'b0000, -1};
        tbl[5]  = '{4'b1001, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b0000,  3};
        tbl[6]  = '{4'b1001, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b1000,  3};
        tbl[7]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001,  0};
        tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001,  0};
        tbl[10] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1};
        tbl[11] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0001,  0};
        tbl[12] = '{4'b0111, 4'b0111, 1'b1, 1'b1, 1'b1, 4'b0001,  0};
        tbl[13] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0000, -1};
        tbl[14] = '{4'b0110, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0010,  1};
        tbl[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1};

        // Reset state with every input asserted.
        axi_reset = 1'b1; m_ready = 1'b1; s_tvalid = 4'hF; s_tlast = 4'hF;
        s_tdata = '1; s_tstrb = '1; s_tuser = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_mdata", m_tdata, 64'd0);
        chk("rst_mlast", m_tlast, 1'b0);
        chk("rst_sready", s_tready, 4'b0000);

        // Idle for 10 cycles.
        do_reset();
        m_ready = 1'b1;
        repeat (10) tick();

        // Directed vector table.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_tdata[i*64 +: 64]   = mk_data(i, 0, 0);
            s_tuser[i*128 +: 128] = mk_user(i, 0, 0);
            s_tstrb[i*8 +: 8]     = mk_strb(i, 0);
        end
        for (int r = 0; r < 16; r++) begin
            s_tvalid = tbl[r].v; s_tlast = tbl[r].l; m_ready = tbl[r].r;
            tick();
            chk($sformatf("tbl%0d_mvalid", r), obs_mvalid, tbl[r].ev);
            chk($sformatf("tbl%0d_mlast", r), obs_mlast, tbl[r].el);
            chk($sformatf("tbl%0d_sready", r), obs_sready, tbl[r].er);
            chk($sformatf("tbl%0d_mdata", r), obs_mdata,
                (tbl[r].ep < 0) ? 64'd0 : mk_data(tbl[r].ep, 0, 0));
        end

        // Contention: all four ports stream 2-beat packets.
        do_reset();
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        fixed_len = 2; m_ready = 1'b1;
        for (int i = 0; i < 60 && done_port.size() < 5; i++) src_tick();
        chk("cont_done", done_port.size() >= 5, 1'b1);
        if (done_port.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("cont_order%0d", k), done_port[k], k % 4);
            for (int k = 1; k < 5; k++) chk($sformatf("cont_gap%0d", k), done_cyc[k] - done_cyc[k-1], 3);
        end

        // Backpressure: port 1 sends 4 beats while tready toggles.
        do_reset();
        en[1] = 1'b1; fixed_len = 4; plen[1] = 4; limit[1] = 1;
        hs1 = 0;
        for (int i = 0; i < 40 && pkt[1] < 1; i++) begin
            m_ready = (i % 2 == 1);
            src_tick();
            if (hs[1]) hs1++;
        end
        chk("bp_handshakes", hs1, 4);

        // Reset mid-packet from port 3.
        do_reset();
        en[3] = 1'b1; fixed_len = 5; plen[3] = 5; m_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_sources();
            if (bidx[3] == 1) begin
                ok = 1'b1;
                break;
            end
            tick();
            advance_sources();
        end
        chk("mid_reached", ok, 1'b1);
        #1 chk("mid_pre_valid", m_tvalid, 1'b1);
        axi_reset = 1'b1;
        #1;
        chk("mid_rst_mvalid", m_tvalid, 1'b0);
        chk("mid_rst_mdata", m_tdata, 64'd0);
        chk("mid_rst_sready", s_tready, 4'b0000);
        do_reset();
        en[0] = 1'b1; en[3] = 1'b1; fixed_len = 1; plen[0] = 1; plen[3] = 1;
        limit[0] = 1; limit[3] = 1; m_ready = 1'b1;
        src_tick();
        src_tick();
        chk("mid_first_port", obs_mdata[63:56], 8'd0);
        chk("mid_first_valid", obs_mvalid, 1'b1);
        repeat (4) src_tick();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        fixed_len = 0; vmode = 1;
        for (int i = 0; i < 4; i++) plen[i] = new_len();
        for (int i = 0; i < 2000; i++) begin
            m_ready = ($urandom_range(3, 0) != 0);
            src_tick();
        end
`ifdef NF10_AXIS_RR_ARBITER_STATS_EN
        for (int i = 0; i < 4; i++) chk($sformatf("rand_cnt%0d", i), pkt_cnt[i*32 +: 32], mcnt[i]);

        // Stats: port 1 sends 5 packets, port 0 sends 2, then a forced wrap.
        do_reset();
        en[0] = 1'b1; en[1] = 1'b1; limit[0] = 2; limit[1] = 5;
        fixed_len = 0; plen[0] = new_len(); plen[1] = new_len(); m_ready = 1'b1;
        for (int i = 0; i < 300 && !(pkt[0] >= 2 && pkt[1] >= 5); i++) src_tick();
        repeat (2) src_tick();
        chk("stats_done", pkt[0] >= 2 && pkt[1] >= 5, 1'b1);
        chk("stats_cnt", pkt_cnt, {32'd0, 32'd0, 32'd5, 32'd2});
        force dut.pkt_cnt_r = {32'd0, 32'hFFFF_FFFF, 32'd5, 32'd2};
        #1 release dut.pkt_cnt_r;
        chk("stats_forced", pkt_cnt[95:64], 32'hFFFF_FFFF);
        en[0] = 1'b0; en[1] = 1'b0; en[2] = 1'b1; limit[2] = 1;
        for (int i = 0; i < 20 && pkt[2] < 1; i++) src_tick();
        repeat (2) src_tick();
        chk("stats_wrap", pkt_cnt, {32'd0, 32'd0, 32'd5, 32'd2});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nf10_axis_rr_arbiter.md
# nf10_axis_rr_arbiter

Packet-granular round-robin arbiter that shares one 64-bit AXI4-Stream converter input among four 64-bit requesters. It sits directly in front of the 64→256 `nf10_axis_converter` instance on the receive path. It grants one whole packet at a time, passes data, strobe and metadata through unchanged, and rotates priority after every packet.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 64, data width of every slave port and the master port.
- C_AXIS_TUSER_WIDTH, 128, tuser width; passed through unmodified.
- C_NUM_PORTS, 4, number of slave ports; fixed at 4, other values unsupported.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  4*C_AXIS_DATA_WIDTH  slave data; port i occupies slice [i*W +: W].
- s_axis_tstrb  in  4*C_AXIS_DATA_WIDTH/8  slave byte strobes, same packing.
- s_axis_tuser  in  4*C_AXIS_TUSER_WIDTH  slave metadata, same packing.
- s_axis_tvalid  in  4  per-port valid.
- s_axis_tlast  in  4  per-port last.
- s_axis_tready  out  4  per-port ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  to converter s_axis_tdata.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  to converter.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  to converter.
- m_axis_tvalid  out  1  to converter.
- m_axis_tlast  out  1  to converter.
- m_axis_tready  in  1  from converter s_axis_tready.
- pkt_cnt  out  4*32  per-port accepted-packet counters; present only with the stats macro.

## Operation
- Two-state FSM:
  - IDLE: no grant.
  - SEND: grant = g, a 2-bit register.
- Round-robin pointer ptr (2 bits) holds the highest-priority port.
- IDLE → SEND: when any s_axis_tvalid is set, g = first port with tvalid scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). The FSM enters SEND on the next edge.
- In SEND, the master port is a combinational mux of port g:
  - m_axis_tdata/tstrb/tuser/tlast/tvalid = port g's signals.
  - s_axis_tready[g] = m_axis_tready.
  - All other s_axis_tready = 0.
- SEND → IDLE: on a beat where m_axis_tvalid & m_axis_tready & m_axis_tlast. On that edge ptr ← g+1 (mod 4), wrapping 3→0.
- In IDLE, every output is driven to 0 and s_axis_tready = 0.
- A granted packet is never preempted. The port holds the grant regardless of gaps where its tvalid is low.
- A port deasserting tvalid while in IDLE before it is selected is not granted; the arbiter samples only.
- Single-beat packets (tvalid & tlast on the first beat) are legal. They occupy one SEND cycle when tready = 1.
- Data is never stored. The block adds no buffering and never modifies tuser, so length/port fields reach the converter intact.

## Timing
- Reset values:
  - FSM = IDLE, ptr = 0, g = 0.
  - All m_axis_* = 0, s_axis_tready = 0.
  - pkt_cnt = 0 when the stats macro is compiled in.
- Arbitration latency: the first beat is presentable one cycle after tvalid is seen in IDLE.
- Packet overhead: exactly one IDLE bubble between consecutive packets. With continuous tready, the first beat of the next packet appears on the second cycle after the previous tlast handshake.
- Master outputs are combinational from slave inputs in SEND (zero-cycle pass-through). m_axis_tready → s_axis_tready is also combinational.
- Asserting axi_reset mid-packet forces IDLE immediately and zeroes all outputs. The partial packet is truncated. Upstream is responsible for flushing it.

## Configuration
- Macro: NF10_AXIS_RR_ARBITER_STATS_EN.
- Defined:
  - pkt_cnt port and four 32-bit counters exist.
  - Counter i increments by 1 on each tlast handshake while g = i. It wraps 0xFFFFFFFF → 0.
  - Counters are cleared only by axi_reset.
- Undefined: pkt_cnt port and counters are absent. Arbitration behaviour is identical.

## Test plan
- Reset then idle: all four tvalid = 0 for 10 cycles → m_axis_tvalid = 0 and s_axis_tready = 4'b0000 throughout.
- Single requester: port 2 sends a 3-beat packet with tready held at 1 → m_axis_tdata shows beats 1–3 on cycles 2–4 after the first tvalid, tlast on beat 3. Then ptr = 3 and the FSM returns to IDLE.
- Contention: all four ports continuously present 2-beat packets from reset → grant order 0, 1, 2, 3, 0 with one bubble cycle between packets. No beat interleaving between ports.
- Backpressure: tready toggles 1, 0, 1, 0 during a 4-beat packet from port 1 → each beat is held stable while tready = 0. Exactly 4 handshakes occur, and s_axis_tready[0,2,3] stays 0.
- Reset mid-packet: assert axi_reset during beat 2 of 5 from port 3 → outputs go to 0 at once. After release, ptr = 0, and port 0 is granted first if ports 0 and 3 both request.
- Stats (macro defined): port 1 sends 5 packets and port 0 sends 2 → pkt_cnt slice 1 = 5, slice 0 = 2, slices 2 and 3 = 0. A counter preloaded via force to 0xFFFFFFFF wraps to 0 on the next packet.
